// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl_if
// Brief    : Control/status bundle between the multi-cycle sequencer and the
//            MIPS datapath (fetch, decode, regfile, ALU, data memory).
// Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic [5:0]           opcode;
    logic [15:0]          imm16;
    logic [25:0]          jtarget;
    logic                 alu_zero;

    logic [PC_WIDTH-1:0]  pc;
    logic                 ir_load;
    logic                 re;
    logic                 we;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 busy;
    logic                 halted;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] instr_count;

    // The sequencer owns the PC and all enables.
    modport master (
        input  start, opcode, imm16, jtarget, alu_zero,
        output pc, ir_load, re, we, reg_write, mem_to_reg,
               busy, halted, illegal, instr_count
    );

    modport slave (
        output start, opcode, imm16, jtarget, alu_zero,
        input  pc, ir_load, re, we, reg_write, mem_to_reg,
               busy, halted, illegal, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Multi-cycle MIPS sequencer (FETCH/DECODE/EXEC/MEM/WB) owning the
//            PC, memory/regfile enables and a saturating retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] PC_RESET  = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input wire logic               clk,
    input wire logic               rst,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_mem    = 3'd4;
    localparam logic [2:0] c_st_wb     = 3'd5;
    localparam logic [2:0] c_st_halt   = 3'd6;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_halt  = 6'b111111;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [5:0]           r_op;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  w_pc_next;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_illegal;
    logic                 w_retire;
    logic                 w_set_illegal;
    logic                 w_op_load;

    logic [PC_WIDTH-1:0]  w_pc_inc;
    logic [PC_WIDTH-1:0]  w_imm_sext;
    logic [PC_WIDTH-1:0]  w_pc_branch;
    logic [PC_WIDTH-1:0]  w_pc_jump;

    generate
        if (PC_WIDTH > 16) begin : g_imm_wide
            assign w_imm_sext = {{(PC_WIDTH-16){bus.imm16[15]}}, bus.imm16};
        end else begin : g_imm_narrow
            assign w_imm_sext = bus.imm16[PC_WIDTH-1:0];
        end

        // j keeps the PC's upper region and replaces the low 26 bits.
        if (PC_WIDTH > 26) begin : g_jump_wide
            assign w_pc_jump = {r_pc[PC_WIDTH-1:26], bus.jtarget};
        end else begin : g_jump_narrow
            assign w_pc_jump = bus.jtarget[PC_WIDTH-1:0];
        end
    endgenerate

    assign w_pc_inc    = r_pc + PC_WIDTH'(1);
    assign w_pc_branch = w_pc_inc + w_imm_sext;

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_op_load     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.start) w_state_next = c_st_fetch;
            end
            c_st_fetch: w_state_next = c_st_decode;
            c_st_decode: begin
                w_op_load = 1'b1;
                case (bus.opcode)
                    c_op_rtype, c_op_lw, c_op_sw, c_op_beq: w_state_next = c_st_exec;
                    c_op_j: begin
                        w_pc_next    = w_pc_jump;
                        w_retire     = 1'b1;
                        w_state_next = c_st_fetch;
                    end
                    c_op_halt: begin
                        w_retire     = 1'b1;
                        w_state_next = c_st_halt;
                    end
                    default: begin
                        w_set_illegal = 1'b1;
                        w_state_next  = c_st_halt;
                    end
                endcase
            end
            c_st_exec: begin
                case (r_op)
                    c_op_rtype:       w_state_next = c_st_wb;
                    c_op_lw, c_op_sw: w_state_next = c_st_mem;
                    c_op_beq: begin
                        w_pc_next    = bus.alu_zero ? w_pc_branch : w_pc_inc;
                        w_retire     = 1'b1;
                        w_state_next = c_st_fetch;
                    end
                    default:          w_state_next = c_st_halt;
                endcase
            end
            c_st_mem: begin
                if (r_op == c_op_lw) begin
                    w_state_next = c_st_wb;
                end else begin
                    w_pc_next    = w_pc_inc;
                    w_retire     = 1'b1;
                    w_state_next = c_st_fetch;
                end
            end
            c_st_wb: begin
                w_pc_next    = w_pc_inc;
                w_retire     = 1'b1;
                w_state_next = c_st_fetch;
            end
            c_st_halt: w_state_next = c_st_halt;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= PC_RESET;
            r_op      <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_op_load) r_op <= bus.opcode;
            if (w_retire && !(&r_count)) r_count <= r_count + CNT_WIDTH'(1);
            if (w_set_illegal) r_illegal <= 1'b1;
        end
    end

    // Every enable is a pure decode of registered state, so reset clears them at once.
    assign bus.pc          = r_pc;
    assign bus.ir_load     = (r_state == c_st_fetch);
    assign bus.re          = (r_state == c_st_mem) && (r_op == c_op_lw);
    assign bus.we          = (r_state == c_st_mem) && (r_op == c_op_sw);
    assign bus.reg_write   = (r_state == c_st_wb);
    assign bus.mem_to_reg  = (r_state == c_st_wb) && (r_op == c_op_lw);
    assign bus.busy        = (r_state != c_st_idle) && (r_state != c_st_halt);
    assign bus.halted      = (r_state == c_st_halt);
    assign bus.illegal     = r_illegal;
    assign bus.instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Brief    : Self-checking bench; an instruction-level latency/retire model
//            predicts every output each cycle for directed and random programs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    localparam int         c_pcw     = 32;
    localparam int         c_cw      = 4;
    localparam logic [5:0] c_op_r    = 6'b000000;
    localparam logic [5:0] c_op_lw   = 6'b100011;
    localparam logic [5:0] c_op_sw   = 6'b101011;
    localparam logic [5:0] c_op_beq  = 6'b000100;
    localparam logic [5:0] c_op_j    = 6'b000010;
    localparam logic [5:0] c_op_halt = 6'b111111;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.PC_WIDTH(c_pcw), .CNT_WIDTH(c_cw)) bus ();

    mips_multicycle_ctrl #(
        .PC_WIDTH (c_pcw),
        .PC_RESET ('0),
        .CNT_WIDTH(c_cw)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Instruction memory indexed by pc[3:0]
    logic [5:0]  mem_op  [16];
    logic [15:0] mem_imm [16];
    logic [25:0] mem_jt  [16];

    // Model: mode 0 idle, 1 running, 2 halted; step = cycle within the instruction
    int          m_mode;
    int          m_step;
    logic [5:0]  m_op;
    logic [31:0] m_pc;
    logic [3:0]  m_cnt;
    logic        m_ill;
    int          n_beq;
    int          cyc;
    logic [31:0] f_pc [$];
    int          f_cyc [$];

    function automatic int inst_len(input logic [5:0] op);
        case (op)
            c_op_r:   return 4;
            c_op_lw:  return 5;
            c_op_sw:  return 4;
            c_op_beq: return 3;
            default:  return 2;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op == c_op_r || op == c_op_lw || op == c_op_sw || op == c_op_beq ||
               op == c_op_j || op == c_op_halt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_op = '0; m_pc = '0; m_cnt = '0; m_ill = 1'b0;
    endtask

    task automatic retire();
        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    endtask

    task automatic check_outputs();
        logic run;
        logic last;
        run  = (m_mode == 1);
        last = run && m_step >= 2 && m_step == inst_len(m_op) - 1;
        chk("ir_load",     32'(bus.ir_load),    32'(run && m_step == 0));
        chk("re",          32'(bus.re),         32'(run && m_step == 3 && m_op == c_op_lw));
        chk("we",          32'(bus.we),         32'(run && m_step == 3 && m_op == c_op_sw));
        chk("reg_write",   32'(bus.reg_write),  32'(last && (m_op == c_op_r || m_op == c_op_lw)));
        chk("mem_to_reg",  32'(bus.mem_to_reg), 32'(last && m_op == c_op_lw));
        chk("busy",        32'(bus.busy),       32'(run));
        chk("halted",      32'(bus.halted),     32'(m_mode == 2));
        chk("illegal",     32'(bus.illegal),    32'(m_ill));
        chk("pc",          bus.pc,              m_pc);
        chk("instr_count", 32'(bus.instr_count), 32'(m_cnt));
    endtask

    // Predict the effect of the next rising edge from the inputs now on the bus.
    task automatic advance();
        case (m_mode)
            0: if (bus.start) begin m_mode = 1; m_step = 0; end
            1: begin
                if (m_step == 0) begin
                    m_step = 1;
                end else if (m_step == 1) begin
                    m_op = bus.opcode;
                    if (m_op == c_op_j) begin
                        m_pc = {m_pc[31:26], bus.jtarget};
                        retire();
                        m_step = 0;
                    end else if (m_op == c_op_halt) begin
                        retire();
                        m_mode = 2;
                    end else if (!is_legal(m_op)) begin
                        m_ill  = 1'b1;
                        m_mode = 2;
                    end else begin
                        m_step = 2;
                    end
                end else if (m_step < inst_len(m_op) - 1) begin
                    m_step++;
                end else begin
                    if (m_op == c_op_beq && bus.alu_zero)
                        m_pc = m_pc + 32'd1 + {{16{bus.imm16[15]}}, bus.imm16};
                    else
                        m_pc = m_pc + 32'd1;
                    if (m_op == c_op_beq) n_beq++;
                    retire();
                    m_step = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input logic st, input logic az);
        @(negedge clk);
        check_outputs();
        if (m_mode == 1 && m_step == 0) begin
            f_pc.push_back(bus.pc);
            f_cyc.push_back(cyc);
        end
        cyc++;
        bus.start    = st;
        bus.alu_zero = az;
        bus.opcode   = mem_op[m_pc[3:0]];
        bus.imm16    = mem_imm[m_pc[3:0]];
        bus.jtarget  = mem_jt[m_pc[3:0]];
        advance();
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0; bus.alu_zero = 1'b0; bus.opcode = '0; bus.imm16 = '0; bus.jtarget = '0;
        model_reset();
        n_beq = 0;
        f_pc.delete();
        f_cyc.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Asynchronous reset pulse between edges; enables must drop with no clock.
    task automatic mid_reset();
        #1 rst = 1'b1;
        #1;
        chk("async_rst_re",     32'(bus.re),          32'd0);
        chk("async_rst_we",     32'(bus.we),          32'd0);
        chk("async_rst_busy",   32'(bus.busy),        32'd0);
        chk("async_rst_halted", 32'(bus.halted),      32'd0);
        chk("async_rst_pc",     bus.pc,               32'd0);
        chk("async_rst_count",  32'(bus.instr_count), 32'd0);
        rst = 1'b0;
        model_reset();
        advance();
    endtask

    task automatic fill_mem(input logic [5:0] op);
        for (int i = 0; i < 16; i++) begin
            mem_op[i] = op; mem_imm[i] = '0; mem_jt[i] = '0;
        end
    endtask

    task automatic run_until_halt(input int budget);
        int n;
        n = 0;
        while (m_mode != 2 && n < budget) begin
            cycle(1'b1, n_beq == 0);
            n++;
        end
        cycle(1'b0, 1'b0);
        chk("halt_reached", 32'(bus.halted), 32'd1);
    endtask

    function automatic logic [5:0] rand_op();
        int         r;
        logic [5:0] o;
        r = $urandom_range(0, 39);
        if (r < 10) return c_op_r;
        if (r < 17) return c_op_lw;
        if (r < 24) return c_op_sw;
        if (r < 31) return c_op_beq;
        if (r < 38) return c_op_j;
        if (r == 38) return c_op_halt;
        do o = 6'($urandom); while (is_legal(o));
        return o;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc1 [9];
        int          exp_lat1 [8];
        logic [31:0] exp_pc2 [4];
        int          exp_lat2 [3];
        logic        was_mem;

        rst = 1'b1;
        cyc = 0;
        model_reset();
        n_beq = 0;

        // Program 1: R, lw, R, sw, beq taken back, sw, beq not taken, j, halt
        exp_pc1  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd3, 32'd4, 32'd5, 32'd6};
        exp_lat1 = '{4, 5, 4, 4, 3, 4, 3, 2};
        fill_mem(c_op_halt);
        mem_op[0] = c_op_r;   mem_op[1] = c_op_lw; mem_op[2] = c_op_r; mem_op[3] = c_op_sw;
        mem_op[4] = c_op_beq; mem_imm[4] = 16'hFFFE;
        mem_op[5] = c_op_j;   mem_jt[5] = 26'h6;
        hard_reset();
        run_until_halt(200);
        chk("p1_fetches", f_pc.size(), 32'd9);
        for (int k = 0; k < 9 && k < f_pc.size(); k++) chk("p1_fetch_pc", f_pc[k], exp_pc1[k]);
        for (int k = 0; k < 8 && k + 1 < f_cyc.size(); k++)
            chk("p1_latency", f_cyc[k+1] - f_cyc[k], exp_lat1[k]);
        chk("p1_count", 32'(bus.instr_count), 32'd9);
        chk("p1_pc", bus.pc, 32'd6);
        for (int k = 0; k < 6; k++) cycle(1'($urandom_range(0, 1)), 1'b0);
        chk("p1_halt_sticky", 32'(bus.halted), 32'd1);

        // Program 2: negative branch from 0 wraps pc, then wraps back, then illegal
        exp_pc2  = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1};
        exp_lat2 = '{3, 4, 3};
        fill_mem(c_op_halt);
        mem_op[0] = c_op_beq; mem_imm[0] = 16'hFFFE;
        mem_op[15] = c_op_r;
        mem_op[1] = 6'b111110;
        hard_reset();
        run_until_halt(100);
        chk("p2_fetches", f_pc.size(), 32'd4);
        for (int k = 0; k < 4 && k < f_pc.size(); k++) chk("p2_fetch_pc", f_pc[k], exp_pc2[k]);
        for (int k = 0; k < 3 && k + 1 < f_cyc.size(); k++)
            chk("p2_latency", f_cyc[k+1] - f_cyc[k], exp_lat2[k]);
        chk("p2_illegal", 32'(bus.illegal), 32'd1);
        chk("p2_count", 32'(bus.instr_count), 32'd3);

        // Program 3: j-to-self loop saturates the retire counter
        fill_mem(c_op_j);
        hard_reset();
        for (int k = 0; k < 60; k++) cycle(1'b1, 1'b0);
        chk("p3_saturated", 32'(bus.instr_count), 32'hF);

        // Program 4: reset asserted while lw is in its memory cycle
        fill_mem(c_op_lw);
        hard_reset();
        for (int k = 0; k < 20; k++) begin
            was_mem = (m_mode == 1 && m_step == 3 && m_op == c_op_lw);
            cycle(1'b1, 1'b0);
            if (was_mem) begin
                chk("p4_re_before_rst", 32'(bus.re), 32'd1);
                mid_reset();
                break;
            end
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0);

        // Random programs with random start, alu_zero and asynchronous resets
        for (int e = 0; e < 8; e++) begin
            int in_halt;
            for (int i = 0; i < 16; i++) begin
                mem_op[i]  = rand_op();
                mem_imm[i] = 16'($urandom_range(0, 8)) - 16'd4;
                mem_jt[i]  = 26'($urandom_range(0, 15));
            end
            hard_reset();
            in_halt = 0;
            for (int c = 0; c < 300 && in_halt < 5; c++) begin
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 149) == 0) mid_reset();
                if (m_mode == 2) in_halt++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
